// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 4-register pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// It resolves data hazards, control redirects, and I/D memory waits into per-register
// stall/flush vectors plus pc_write. An I-side fetch that is still in flight when a redirect
// arrives is tracked to completion, and its returned word is dropped.
// Optional macro HAZARD_STATS_EN adds 32-bit per-case cycle counters. When it is undefined,
// the stat_* outputs are tied to 0.
module hazard_stall_ctrl #(
  parameter int REG_AW          = 2,
  parameter int DATA_FORWARDING = 1,
  parameter int MEM_LATENCY     = 0,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              is_jr_id,
  input  logic              reg_write_ex,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] dest_ex,
  input  logic [REG_AW-1:0] dest_mem,
  input  logic              mem_read_ex,
  input  logic              branch_miss,
  input  logic              jump_miss,
  input  logic              i_req,
  input  logic              i_ready,
  input  logic              d_req_mem,
  input  logic              d_ready,
  output logic [3:0]        stall,
  output logic [3:0]        flush,
  output logic              pc_write,
  output logic [31:0]       stat_d_stall,
  output logic [31:0]       stat_i_stall,
  output logic [31:0]       stat_data_stall,
  output logic [31:0]       stat_flush
);

  // cycle index of the final cycle of a fixed-latency access
  localparam logic [CNT_W-1:0] LAST = (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic       {D_IDLE, D_WAIT} d_state_t;
  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DISCARD} i_state_t;
  typedef enum logic [2:0] {W_D, W_BR, W_HZ, W_JMP, W_I, W_NONE} win_t;

  d_state_t          d_state, d_state_nx;
  i_state_t          i_state, i_state_nx;
  logic [CNT_W-1:0]  d_cnt, d_cnt_nx, i_cnt, i_cnt_nx;
  logic              d_done, i_done, d_wait, i_wait;
  logic              hz, hz_fwd, hz_all, redirect;
  win_t              win;

  // the counters hold 0 while idle, so they equal the cycle index within the current access
  assign d_done = (MEM_LATENCY == 0) ? d_ready : (d_cnt == LAST);
  assign i_done = (MEM_LATENCY == 0) ? i_ready : (i_cnt == LAST);
  assign d_wait = d_req_mem && !d_done;
  assign i_wait = (i_req && !i_done) || (i_state == I_DISCARD);

  // With forwarding, only a load-use hazard, or a JR target that is not yet in the register file, stalls.
  assign hz_fwd = (mem_read_ex && ((use_rs && rs_id == dest_ex) || (use_rt && rt_id == dest_ex)))
               || (is_jr_id && ((reg_write_ex && rs_id == dest_ex) || (reg_write_mem && rs_id == dest_mem)));
  assign hz_all = ((use_rs || is_jr_id) && ((reg_write_ex && rs_id == dest_ex) || (reg_write_mem && rs_id == dest_mem)))
               || (use_rt && ((reg_write_ex && rt_id == dest_ex) || (reg_write_mem && rt_id == dest_mem)));
  assign hz     = (DATA_FORWARDING != 0) ? hz_fwd : hz_all;

  // A redirect is taken only when it wins priority. A frozen MEM stage hides it; EX re-presents it later.
  assign redirect = !d_wait && (branch_miss || (jump_miss && !hz));

  // state registers for both memory-wait FSMs
  always_ff @(posedge clk) begin
    if (reset) begin
      d_state <= D_IDLE;
      i_state <= I_IDLE;
      d_cnt   <= '0;
      i_cnt   <= '0;
    end else begin
      d_state <= d_state_nx;
      i_state <= i_state_nx;
      d_cnt   <= d_cnt_nx;
      i_cnt   <= i_cnt_nx;
    end
  end

  // D-side next state and saturating access counter
  always_comb begin
    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    case (d_state)
      D_IDLE: if (d_wait) begin
        d_state_nx = D_WAIT;
        d_cnt_nx   = ONE;
      end
      D_WAIT: if (d_done) begin
        d_state_nx = D_IDLE;
        d_cnt_nx   = '0;
      end else if (d_cnt != CMAX) begin
        d_cnt_nx = d_cnt + 1'b1;
      end
      default: begin
        d_state_nx = D_IDLE;
        d_cnt_nx   = '0;
      end
    endcase
  end

  // I-side next state; a redirect during an unfinished fetch turns it into a discard
  always_comb begin
    i_state_nx = i_state;
    i_cnt_nx   = i_cnt;
    case (i_state)
      I_IDLE: if (i_req && !i_done) begin
        i_state_nx = redirect ? I_DISCARD : I_WAIT;
        i_cnt_nx   = ONE;
      end
      I_WAIT, I_DISCARD: if (i_done) begin
        i_state_nx = I_IDLE;
        i_cnt_nx   = '0;
      end else begin
        if (i_state == I_WAIT && redirect) i_state_nx = I_DISCARD;
        if (i_cnt != CMAX) i_cnt_nx = i_cnt + 1'b1;
      end
      default: begin
        i_state_nx = I_IDLE;
        i_cnt_nx   = '0;
      end
    endcase
  end

  // fixed-priority selection of the case that owns the pipeline this cycle
  always_comb begin
    win = W_NONE;
    if      (d_wait)      win = W_D;
    else if (branch_miss) win = W_BR;
    else if (hz)          win = W_HZ;
    else if (jump_miss)   win = W_JMP;
    else if (i_wait)      win = W_I;
  end

  // stall/flush/pc_write decode; reset forces bubbles everywhere and holds the PC
  always_comb begin
    stall    = 4'b0000;
    flush    = 4'b0000;
    pc_write = 1'b1;
    if (reset) begin
      flush    = 4'b1111;
      pc_write = 1'b0;
    end else begin
      case (win)
        W_D:    begin stall = 4'b0111; flush = 4'b1000; pc_write = 1'b0; end
        W_BR:   begin flush = 4'b0011; end
        W_HZ:   begin stall = 4'b0001; flush = 4'b0010; pc_write = 1'b0; end
        W_JMP:  begin flush = 4'b0001; end
        W_I:    begin flush = 4'b0001; pc_write = 1'b0; end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] n_d, n_i, n_h, n_f;

  // per-case cycle counters, free-running wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      n_d <= '0;
      n_i <= '0;
      n_h <= '0;
      n_f <= '0;
    end else begin
      case (win)
        W_D:          n_d <= n_d + 32'd1;
        W_I:          n_i <= n_i + 32'd1;
        W_HZ:         n_h <= n_h + 32'd1;
        W_BR, W_JMP:  n_f <= n_f + 32'd1;
        default: ;
      endcase
    end
  end

  assign stat_d_stall    = n_d;
  assign stat_i_stall    = n_i;
  assign stat_data_stall = n_h;
  assign stat_flush      = n_f;
`else
  assign stat_d_stall    = '0;
  assign stat_i_stall    = '0;
  assign stat_data_stall = '0;
  assign stat_flush      = '0;
`endif

endmodule
